// File: rtl/gba_pak_pkg.sv
// Shared cartridge-bus definitions for the GBA pak writer and reader.
// ST_VERIFY_* states exist only when GBA_SRAM_WRITER_VERIFY_EN is defined.
`timescale 1ns/1ps
package gba_pak_pkg;
    localparam int GBA_SRAM_ADDR_W = 16;
    localparam int GBA_SRAM_DATA_W = 8;
    localparam int GBA_TIMER_W     = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_WAIT_DATA  = 4'd1,
        ST_SETUP      = 4'd2,
        ST_WR_LOW     = 4'd3,
        ST_HOLD       = 4'd4,
        ST_NEXT       = 4'd5,
        ST_DONE       = 4'd6
`ifdef GBA_SRAM_WRITER_VERIFY_EN
        ,
        ST_VERIFY_RD  = 4'd7,
        ST_VERIFY_CMP = 4'd8
`endif
    } gba_sram_state_e;
endpackage

// File: rtl/gba_bus_timer.sv
// Loadable down-counter; o_tc is high during the last cycle of a loaded interval.
`timescale 1ns/1ps
module gba_bus_timer
    import gba_pak_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_load,
    input  logic [GBA_TIMER_W-1:0] i_value,
    output logic                   o_tc
);
    logic [GBA_TIMER_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - GBA_TIMER_W'(1);
        end
    end

    assign o_tc = (r_count == GBA_TIMER_W'(1));
endmodule

// File: rtl/gba_sram_writer.sv
// Streams bytes into GBA cartridge SRAM with registered, timed WR strobes.
// Optional readback check is enabled with GBA_SRAM_WRITER_VERIFY_EN.
`timescale 1ns/1ps
module gba_sram_writer
    import gba_pak_pkg::*;
#(
    parameter int SETUP_CYCLES  = 4,
    parameter int WR_LOW_CYCLES = 8,
    parameter int HOLD_CYCLES   = 2
) (
    input  logic                       pin_clk,
    input  logic                       pin_rst_n,
    input  logic [GBA_SRAM_ADDR_W-1:0] start_address,
    input  logic [GBA_SRAM_ADDR_W-1:0] end_address,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    input  logic [GBA_SRAM_DATA_W-1:0] data_in,
    input  logic                       data_valid,
    output logic                       data_ready,
    output logic                       pin_gbaRD,
    output logic                       pin_gbaWR,
    output logic                       pin_gbaCS,
    output logic                       pin_gbaCS2,
    inout  wire  [GBA_SRAM_ADDR_W-1:0] pin_gbaDataAddressLo,
`ifdef GBA_SRAM_WRITER_VERIFY_EN
    inout  wire  [GBA_SRAM_DATA_W-1:0] pin_gbaAddressHi,
`else
    output logic [GBA_SRAM_DATA_W-1:0] pin_gbaAddressHi,
`endif
    output logic                       verify_error,
    output logic [3:0]                 o_dbg_state,
    output logic                       o_dbg_ad_oe
);
    // Handshake: a byte moves on a rising edge where data_valid && data_ready;
    // data_ready is high only in WAIT_DATA, and data_valid may stay low indefinitely.
    gba_sram_state_e r_state, w_next_state;

    logic [GBA_SRAM_ADDR_W:0]   r_addr;
    logic [GBA_SRAM_ADDR_W-1:0] r_end;
    logic [GBA_SRAM_ADDR_W-1:0] r_ad;
    logic [GBA_SRAM_DATA_W-1:0] r_data;
    logic                       r_ad_oe, r_wr_n, r_rd_n, r_cs2_n;
    logic                       w_accept, w_capture, w_last, w_tc;
    logic                       w_tmr_load;
    logic [GBA_TIMER_W-1:0]     w_tmr_value;
    logic                       w_wr_n, w_rd_n, w_cs2_n, w_ad_oe;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_capture = (r_state == ST_WAIT_DATA) && data_valid;
    // 17-bit compare so a run ending at 0xFFFF never wraps to 0x0000
    assign w_last    = (r_addr == {1'b0, r_end});

    gba_bus_timer u_timer (
        .i_clk   (pin_clk),
        .i_rst_n (pin_rst_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_value),
        .o_tc    (w_tc)
    );

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (start_address > end_address) ? ST_DONE : ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: if (data_valid) w_next_state = ST_SETUP;
            ST_SETUP:     if (w_tc) w_next_state = ST_WR_LOW;
            ST_WR_LOW:    if (w_tc) w_next_state = ST_HOLD;
            ST_HOLD: begin
                if (w_tc) begin
`ifdef GBA_SRAM_WRITER_VERIFY_EN
                    w_next_state = ST_VERIFY_RD;
`else
                    w_next_state = ST_NEXT;
`endif
                end
            end
`ifdef GBA_SRAM_WRITER_VERIFY_EN
            ST_VERIFY_RD:  if (w_tc) w_next_state = ST_VERIFY_CMP;
            ST_VERIFY_CMP: w_next_state = ST_NEXT;
`endif
            ST_NEXT: w_next_state = w_last ? ST_DONE : ST_WAIT_DATA;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Strobes are computed from the next state and registered below.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = '0;
        w_wr_n      = (w_next_state != ST_WR_LOW);
        w_rd_n      = 1'b1;
        w_cs2_n     = r_cs2_n;
        w_ad_oe     = r_ad_oe;
        case (r_state)
            ST_WAIT_DATA: begin
                if (data_valid) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = GBA_TIMER_W'(SETUP_CYCLES);
                    w_cs2_n     = 1'b0;
                    w_ad_oe     = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_tc) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = GBA_TIMER_W'(WR_LOW_CYCLES);
                end
            end
            ST_WR_LOW: begin
                if (w_tc) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = GBA_TIMER_W'(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
`ifdef GBA_SRAM_WRITER_VERIFY_EN
                if (w_tc) begin
                    w_tmr_load  = 1'b1;
                    w_tmr_value = GBA_TIMER_W'(WR_LOW_CYCLES);
                end
`endif
            end
            default: begin
            end
        endcase
        if ((w_next_state == ST_DONE) || (w_next_state == ST_IDLE)) begin
            w_cs2_n = 1'b1;
            w_ad_oe = 1'b0;
        end
`ifdef GBA_SRAM_WRITER_VERIFY_EN
        w_rd_n = (w_next_state != ST_VERIFY_RD);
`endif
    end

    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            r_addr  <= '0;
            r_end   <= '0;
            r_ad    <= '0;
            r_data  <= '0;
            r_ad_oe <= 1'b0;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
            r_cs2_n <= 1'b1;
        end else begin
            r_wr_n  <= w_wr_n;
            r_rd_n  <= w_rd_n;
            r_cs2_n <= w_cs2_n;
            r_ad_oe <= w_ad_oe;
            if (w_accept) begin
                r_addr <= {1'b0, start_address};
                r_end  <= end_address;
            end else if ((r_state == ST_NEXT) && !w_last) begin
                r_addr <= r_addr + 17'd1;
            end
            if (w_capture) begin
                r_ad   <= r_addr[GBA_SRAM_ADDR_W-1:0];
                r_data <= data_in;
            end
        end
    end

`ifdef GBA_SRAM_WRITER_VERIFY_EN
    logic                       r_hi_oe;
    logic                       r_verify_error;
    logic [GBA_SRAM_DATA_W-1:0] r_rd_data;

    // The data byte shares the A23..A16 pins, so it is released while RD is low.
    always_ff @(posedge pin_clk or negedge pin_rst_n) begin
        if (!pin_rst_n) begin
            r_hi_oe        <= 1'b1;
            r_verify_error <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            r_hi_oe <= (w_next_state != ST_VERIFY_RD);
            if (r_state == ST_VERIFY_RD) begin
                r_rd_data <= pin_gbaAddressHi;
            end
            if (w_accept) begin
                r_verify_error <= 1'b0;
            end else if ((r_state == ST_VERIFY_CMP) && (r_rd_data != r_data)) begin
                r_verify_error <= 1'b1;
            end
        end
    end

    assign pin_gbaAddressHi = r_hi_oe ? r_data : {GBA_SRAM_DATA_W{1'bz}};
    assign verify_error     = r_verify_error;
`else
    assign pin_gbaAddressHi = r_data;
    assign verify_error     = 1'b0;
`endif

    assign pin_gbaDataAddressLo = r_ad_oe ? r_ad : {GBA_SRAM_ADDR_W{1'bz}};
    assign pin_gbaWR    = r_wr_n;
    assign pin_gbaRD    = r_rd_n;
    assign pin_gbaCS    = 1'b1;
    assign pin_gbaCS2   = r_cs2_n;
    assign busy         = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done         = (r_state == ST_DONE);
    assign data_ready   = (r_state == ST_WAIT_DATA);
    assign o_dbg_state  = r_state;
    assign o_dbg_ad_oe  = r_ad_oe;
endmodule
